// File: rtl/sim_halt_dump_ctrl.sv
// rtl/sim_halt_dump_ctrl.sv - end-of-run halt on trap word or timeout, then DMEM window dump
// Optional running rotate-XOR checksum of dumped words: SIM_HALT_DUMP_CHECKSUM_EN.

module sim_halt_dump_ctrl #(
   parameter int          DATA_W         = 32,
   parameter int          ADDR_W         = 32,
   parameter logic [31:0] TRAP_WORD      = 32'h44000300,
   parameter int          DUMP_BASE      = 8192,
   parameter int          DUMP_WORDS     = 10,
   parameter int          BYTES_PER_WORD = 4,
   parameter int          DRAIN_CYCLES   = 4,
   parameter int          TIMEOUT_CYCLES = 25000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              instr_valid,
   input  logic [31:0]       instr,
   output logic              halt_req,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              dump_last,
   output logic              done,
   output logic              timed_out,
   output logic [31:0]       cycle_count,
   output logic [DATA_W-1:0] dump_checksum
);

   localparam int                DRN_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DRN_W-1:0]  drain_last  = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [15:0]       last_idx    = 16'(DUMP_WORDS - 1);
   localparam logic [ADDR_W-1:0] base_addr   = ADDR_W'(DUMP_BASE);
   localparam logic [ADDR_W-1:0] stride      = ADDR_W'(BYTES_PER_WORD);
   localparam logic [31:0]       timeout_end = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit                timeout_en  = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {
      st_run,
      st_drain,
      st_read,
      st_capture,
      st_present,
      st_done
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [DRN_W-1:0]  drain_cnt;
   logic [15:0]       idx;
   logic [ADDR_W-1:0] rd_addr;
   logic              trap_hit;
   logic              timeout_hit;
   logic              accept;

   assign trap_hit    = instr_valid && (instr == TRAP_WORD);
   assign timeout_hit = timeout_en && (cycle_count == timeout_end);
   assign accept      = (state == st_present) && dump_ready;
   assign mem_addr    = rd_addr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= st_run;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mem_rd_en  = 1'b0;
      dump_valid = 1'b0;
      dump_last  = 1'b0;
      done       = 1'b0;
      case (state)
         st_run: begin
            if (trap_hit || timeout_hit) begin
               state_nx = st_drain;
            end
         end
         st_drain: begin
            if ((DRAIN_CYCLES == 0) || (drain_cnt == drain_last)) begin
               state_nx = st_read;
            end
         end
         st_read: begin
            mem_rd_en = 1'b1;
            state_nx  = st_capture;
         end
         st_capture: begin
            state_nx = st_present;
         end
         st_present: begin
            dump_valid = 1'b1;
            dump_last  = (idx == last_idx);
            if (dump_ready) begin
               state_nx = (idx == last_idx) ? st_done : st_read;
            end
         end
         st_done: begin
            done = 1'b1;
         end
         default: begin
            state_nx = st_run;
         end
      endcase
   end

   // cycle_count stops on the halting edge itself, so it reads the cycle index of the trap/timeout
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         halt_req    <= 1'b0;
         timed_out   <= 1'b0;
         cycle_count <= '0;
         drain_cnt   <= '0;
         idx         <= '0;
         rd_addr     <= '0;
         dump_addr   <= '0;
         dump_data   <= '0;
      end else begin
         case (state)
            st_run: begin
               if (trap_hit || timeout_hit) begin
                  halt_req  <= 1'b1;
                  timed_out <= !trap_hit;
                  drain_cnt <= '0;
                  idx       <= '0;
                  rd_addr   <= base_addr;
               end else if (cycle_count != 32'hFFFF_FFFF) begin
                  cycle_count <= cycle_count + 32'd1;
               end
            end
            st_drain: begin
               drain_cnt <= drain_cnt + DRN_W'(1);
            end
            st_capture: begin
               dump_data <= mem_rd_data;
               dump_addr <= rd_addr;
            end
            st_present: begin
               if (accept) begin
                  idx     <= idx + 16'd1;
                  rd_addr <= rd_addr + stride;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SIM_HALT_DUMP_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dump_checksum <= '0;
      end else if (accept) begin
         dump_checksum <= {dump_checksum[DATA_W-2:0], dump_checksum[DATA_W-1]} ^ dump_data;
      end
   end
`else
   assign dump_checksum = '0;
`endif

endmodule

// File: tb/tb_sim_halt_dump_ctrl.sv
// tb/tb_sim_halt_dump_ctrl.sv - scoreboard bench for sim_halt_dump_ctrl
// Checksum expectations follow SIM_HALT_DUMP_CHECKSUM_EN.

module tb_sim_halt_dump_ctrl;

   localparam logic [31:0] trap = 32'h44000300;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        halt_req;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data = '0;
   logic        dump_valid;
   logic        dump_ready = 1'b1;
   logic [31:0] dump_addr;
   logic [31:0] dump_data;
   logic        dump_last;
   logic        done;
   logic        timed_out;
   logic [31:0] cycle_count;
   logic [31:0] dump_checksum;

   always #5 clock = ~clock;

   sim_halt_dump_ctrl #(.TIMEOUT_CYCLES(100)) dut (
      .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
      .halt_req(halt_req), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
      .mem_rd_data(mem_rd_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data), .dump_last(dump_last),
      .done(done), .timed_out(timed_out), .cycle_count(cycle_count),
      .dump_checksum(dump_checksum)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] dmem [0:15];
   logic [31:0] exp_csum;
   bit          bp_mode = 1'b0;
   int          beats_acc = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // DMEM model: data valid only in the cycle after the strobe, garbage otherwise
   always @(posedge clock) begin
      mem_rd_data <= mem_rd_en ? dmem[mem_addr[5:2]] : 32'hBADB_AD00;
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         dump_ready = bp_mode ? ($urandom_range(0, 99) >= 70) : 1'b1;
      end
   end

   initial begin
      bit          stall;
      logic [31:0] sa;
      logic [31:0] sd;
      logic        sl;
      beat_t       b;
      stall = 1'b0;
      forever begin
         @(negedge clock);
         if (stall && reset) begin
            check_eq("hold_valid", 64'(dump_valid), 64'(1));
            check_eq("hold_addr", 64'(dump_addr), 64'(sa));
            check_eq("hold_data", 64'(dump_data), 64'(sd));
            check_eq("hold_last", 64'(dump_last), 64'(sl));
         end
         stall = 1'b0;
         if (dump_valid && !dump_ready) begin
            stall = 1'b1;
            sa = dump_addr;
            sd = dump_data;
            sl = dump_last;
         end
         if (dump_valid && dump_ready) begin
            check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               b = exp_q.pop_front();
               check_eq("beat_addr", 64'(dump_addr), 64'(b.addr));
               check_eq("beat_data", 64'(dump_data), 64'(b.data));
               check_eq("beat_last", 64'(dump_last), 64'(b.last));
            end
            beats_acc++;
         end
      end
   end

   task automatic check_outputs_zero();
      check_eq("rst_halt", 64'(halt_req), 64'(0));
      check_eq("rst_rd_en", 64'(mem_rd_en), 64'(0));
      check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
      check_eq("rst_valid", 64'(dump_valid), 64'(0));
      check_eq("rst_dump_addr", 64'(dump_addr), 64'(0));
      check_eq("rst_dump_data", 64'(dump_data), 64'(0));
      check_eq("rst_last", 64'(dump_last), 64'(0));
      check_eq("rst_done", 64'(done), 64'(0));
      check_eq("rst_timed_out", 64'(timed_out), 64'(0));
      check_eq("rst_cycles", 64'(cycle_count), 64'(0));
      check_eq("rst_checksum", 64'(dump_checksum), 64'(0));
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      instr_valid = 1'b0;
      instr = '0;
      repeat (2) @(posedge clock);
      #1;
      check_outputs_zero();
      exp_q.delete();
      beats_acc = 0;
      reset = 1'b1;
   endtask

   task automatic load_and_expect(input bit seq);
      beat_t b;
      exp_csum = '0;
      for (int i = 0; i < 16; i++) begin
         dmem[i] = seq ? 32'(i + 1) : $urandom;
      end
      for (int i = 0; i < 10; i++) begin
         b.addr = 32'(8192 + 4 * i);
         b.data = dmem[i];
         b.last = (i == 9);
         exp_q.push_back(b);
         exp_csum = {exp_csum[30:0], exp_csum[31]} ^ dmem[i];
      end
   endtask

   task automatic run_until(input int target, input bit use_trap);
      int          n;
      logic [31:0] v;
      n = 0;
      while (n < 400 && (use_trap ? (cycle_count != 32'(target)) : !halt_req)) begin
         v = $urandom;
         if (v == trap) v = 32'h0;
         instr_valid = $urandom_range(0, 1);
         instr = instr_valid ? v : trap;
         @(posedge clock);
         #1;
         n++;
      end
      instr_valid = 1'b0;
      instr = '0;
      if (use_trap) begin
         check_eq("pre_trap_count", 64'(cycle_count), 64'(target));
         check_eq("pre_trap_halt", 64'(halt_req), 64'(0));
         instr_valid = 1'b1;
         instr = trap;
         @(posedge clock);
         #1;
         instr_valid = 1'b0;
         instr = '0;
      end
   endtask

   task automatic check_latency();
      int n;
      n = 0;
      while (!dump_valid && n < 50) begin
         @(posedge clock);
         #1;
         n++;
      end
      check_eq("first_valid_latency", 64'(n), 64'(6));
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clock);
         #1;
         n++;
      end
      @(posedge clock);
      #1;
      check_eq("done", 64'(done), 64'(1));
      check_eq("queue_drained", 64'(exp_q.size()), 64'(0));
      check_eq("beat_count", 64'(beats_acc), 64'(10));
      check_eq("done_valid", 64'(dump_valid), 64'(0));
      check_eq("done_rd_en", 64'(mem_rd_en), 64'(0));
`ifdef SIM_HALT_DUMP_CHECKSUM_EN
      check_eq("checksum", 64'(dump_checksum), 64'(exp_csum));
`else
      check_eq("checksum_off", 64'(dump_checksum), 64'(0));
`endif
   endtask

   initial begin
      // trap at cycle 20, ready held high, sequential data 1..10
      apply_reset();
      load_and_expect(1'b1);
      run_until(20, 1'b1);
      check_eq("trap_halt", 64'(halt_req), 64'(1));
      check_eq("trap_count", 64'(cycle_count), 64'(20));
      check_eq("trap_timed_out", 64'(timed_out), 64'(0));
      check_latency();
      wait_done();
      instr_valid = 1'b1;
      instr = trap;
      repeat (3) @(posedge clock);
      #1;
      instr_valid = 1'b0;
      check_eq("late_trap_done", 64'(done), 64'(1));
      check_eq("late_trap_valid", 64'(dump_valid), 64'(0));
      check_eq("late_trap_count", 64'(cycle_count), 64'(20));
      check_eq("late_trap_halt", 64'(halt_req), 64'(1));

      // backpressure with ~70% ready-low duty
      apply_reset();
      load_and_expect(1'b0);
      bp_mode = 1'b1;
      run_until(30, 1'b1);
      check_eq("bp_halt", 64'(halt_req), 64'(1));
      check_latency();
      wait_done();
      bp_mode = 1'b0;

      // timeout only
      apply_reset();
      load_and_expect(1'b0);
      run_until(0, 1'b0);
      check_eq("to_halt", 64'(halt_req), 64'(1));
      check_eq("to_timed_out", 64'(timed_out), 64'(1));
      check_eq("to_count", 64'(cycle_count), 64'(99));
      wait_done();

      // trap coincides with timeout
      apply_reset();
      load_and_expect(1'b0);
      run_until(99, 1'b1);
      check_eq("tie_halt", 64'(halt_req), 64'(1));
      check_eq("tie_timed_out", 64'(timed_out), 64'(0));
      check_eq("tie_count", 64'(cycle_count), 64'(99));
      wait_done();

      // asynchronous reset mid-dump, then a fresh full dump
      apply_reset();
      load_and_expect(1'b0);
      run_until(10, 1'b1);
      begin
         int n;
         n = 0;
         while (beats_acc < 4 && n < 500) begin
            @(posedge clock);
            n++;
         end
         check_eq("mid_beats", 64'(beats_acc), 64'(4));
      end
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check_outputs_zero();
      apply_reset();
      load_and_expect(1'b0);
      run_until(15, 1'b1);
      check_eq("rerun_halt", 64'(halt_req), 64'(1));
      check_latency();
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
